tbuf_bus_arbiter: RTL
=====================

TBUF_BUS_ARBITER -- requirements
Module: tbuf_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one tri-state bus, legal 2..8.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per owner, legal 1..255.
REQ-003 Parameter TURN_CYC, default 1: bus-park cycles between owners, legal 1..3.
REQ-004 CK  input  1  clock, rising edge; the block has exactly one clock.
REQ-005 RN  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester bus request, level, held until done.
REQ-007 gnt  output  NREQ  registered one-hot grant.
REQ-008 oen  output  NREQ  registered active-low drive enable per TBUF/PADBID OEN; always equals ~gnt.
REQ-009 busy  output  1  high while any gnt bit is set.
REQ-010 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE (no owner), GRANT (one owner), TURN (bus parked, all oen high).
REQ-012 IDLE: if any req bit is set, the block SHALL pick a winner and assert its gnt on the next CK edge (1-cycle latency), then enter GRANT.
REQ-013 Arbitration SHALL be round-robin: the search starts at last_owner+1 modulo NREQ, and the first set req bit wins.
REQ-014 GRANT: when req[owner] is low at a CK edge, gnt SHALL clear on that edge and the FSM SHALL enter TURN.
REQ-015 A hold counter SHALL count the GRANT cycles of the current owner.
REQ-016 When the hold counter reaches MAX_HOLD, gnt SHALL clear on that edge regardless of req[owner].
REQ-017 On the same edge as REQ-016, timeout SHALL pulse for one cycle and the FSM SHALL enter TURN.
REQ-018 TURN SHALL last exactly TURN_CYC cycles with gnt all 0, then go to IDLE; arbitration resumes from IDLE per REQ-012.
REQ-019 Request changes during TURN SHALL be ignored until IDLE is reached.
REQ-020 A previous owner still requesting after TURN SHALL be re-granted only if no other req bit is set (rotation per REQ-013).
REQ-021 At most one gnt bit SHALL be set in any cycle; between two distinct owners there SHALL be at least TURN_CYC cycles with all oen high.
REQ-022 If owner release and timeout coincide, TURN SHALL be entered once and timeout SHALL pulse.
REQ-023 busy SHALL equal |gnt, combinationally from registered state.

Reset
REQ-024 While RN is low, asynchronously: gnt=0, oen=all 1, busy=0, timeout=0, FSM=IDLE, hold counter=0.
REQ-025 While RN is low, last_owner SHALL be NREQ-1, so req[0] has top priority after reset.
REQ-026 RN asserted mid-GRANT SHALL release the bus immediately without waiting for an edge; after RN deasserts, the first arbitration is on the first CK edge.

Configuration
REQ-027 Macro TBUF_BUS_ARBITER_TIMEOUT_EN defined: hold counter, MAX_HOLD forced release and the timeout pulse are present as in REQ-015..REQ-017 and REQ-022.
REQ-028 Macro TBUF_BUS_ARBITER_TIMEOUT_EN undefined: no hold counter is built, MAX_HOLD is ignored, timeout is tied 0, and the owner keeps the grant until req[owner] drops.

Structure
REQ-029 Package tbuf_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT, TURN), the hold-counter width constant (8) and the turnaround-counter width constant (2).
REQ-030 Sub-module tbuf_arb_rr_pick SHALL be a combinational rotate-priority picker with inputs req and last_owner and outputs winner one-hot and valid.

Verification
REQ-031 Reset, req=4'b0101 -> gnt=4'b0001 one cycle later; oen=4'b1110.
REQ-032 req0 drops with req=4'b0100, TURN_CYC=1 -> one cycle gnt=0 and oen=4'b1111, then gnt=4'b0100.
REQ-033 TIMEOUT_EN defined, MAX_HOLD=16, req=4'b0011 held -> gnt[0] for 16 cycles, timeout pulse, TURN, then gnt=4'b0010.
REQ-034 TIMEOUT_EN undefined, req=4'b0011 held 100 cycles -> gnt=4'b0001 throughout, timeout=0.
REQ-035 RN pulsed low mid-GRANT -> oen=4'b1111 with no CK edge; after release req=4'b1111 -> gnt=4'b0001.
REQ-036 Random req, 10k cycles -> assertions: $onehot0(gnt), oen==~gnt, at least TURN_CYC idle cycles between distinct owners, no requester starved beyond NREQ grants.

Source files
------------

// File: rtl/tbuf_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tbuf_arb_pkg                                                |
// | Description : Shared types and constants for the tri-state bus arbiter.  |
// |               Holds the FSM state encoding and the widths of the hold    |
// |               counter and the bus-park (turnaround) counter.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package tbuf_arb_pkg;

  // Arbiter FSM: IDLE = no owner, GRANT = one owner drives the bus,
  // TURN = bus parked with every driver disabled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Hold counter must cover MAX_HOLD up to 255.
  localparam int HOLD_W = 8;
  // Turnaround counter must cover TURN_CYC up to 3.
  localparam int TURN_W = 2;

endpackage : tbuf_arb_pkg
`default_nettype wire

// File: rtl/tbuf_arb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tbuf_arb_rr_pick                                            |
// | Description : Combinational rotate-priority picker. The search starts at |
// |               last_owner+1 (mod NREQ); the first set req bit wins.       |
// | Ports       : req        in  NREQ   request vector                       |
// |               last_owner in  OWN_W  index of the most recent owner       |
// |               winner     out NREQ   one-hot winner (0 when no request)   |
// |               valid      out 1      any request present                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tbuf_arb_rr_pick #(
  parameter int NREQ  = 4,
  parameter int OWN_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] last_owner,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  logic [NREQ-1:0] w_hi;    // requests strictly above last_owner
  logic [NREQ-1:0] w_pool;  // pool the lowest set bit is taken from

  // Requests above last_owner have priority; if none, wrap around to the
  // full vector. Taking the lowest set bit of the chosen pool is then the
  // same as a circular search starting at last_owner+1.
  always_comb begin
    w_hi = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_hi[j] = req[j] && (j > int'(last_owner));
    end
    w_pool = (|w_hi) ? w_hi : req;
    // Two's-complement trick isolates the lowest set bit.
    winner = w_pool & (~w_pool + NREQ'(1));
    valid  = |req;
  end

endmodule : tbuf_arb_rr_pick
`default_nettype wire

// File: rtl/tbuf_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tbuf_bus_arbiter                                            |
// | Description : Round-robin owner arbiter for a shared tri-state bus with  |
// |               registered one-hot grants, active-low per-driver output    |
// |               enables and a guaranteed bus-park gap between owners.      |
// | Ports       : CK      in  1     clock, rising edge                       |
// |               RN      in  1     asynchronous active-low reset            |
// |               req     in  NREQ  per-requester level request              |
// |               gnt     out NREQ  registered one-hot grant                 |
// |               oen     out NREQ  registered active-low drive enable       |
// |               busy    out 1     any grant active                         |
// |               timeout out 1     one-cycle pulse on forced release        |
// | Build macro : TBUF_BUS_ARBITER_TIMEOUT_EN -- when defined, an owner is    |
// |               forcibly released after MAX_HOLD grant cycles and timeout  |
// |               pulses; when undefined there is no hold counter and the    |
// |               owner keeps the bus until its request drops.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic            CK,
  input  logic            RN,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] oen,
  output logic            busy,
  output logic            timeout
);

  localparam int OWN_W = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  oen_q;
  logic [OWN_W-1:0] last_q, last_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic [NREQ-1:0]  w_win;
  logic             w_valid;
  logic [OWN_W-1:0] w_win_idx;
  logic             w_req_own;
  logic             w_hold_done;

  tbuf_arb_rr_pick #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .winner     (w_win),
    .valid      (w_valid)
  );

  // Index of the one-hot winner, remembered as the next rotation origin.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) w_win_idx = OWN_W'(i);
    end
  end

  // gnt_q is one-hot in GRANT, so this is req[owner] without a variable index.
  assign w_req_own = |(req & gnt_q);

`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  assign w_hold_done = (hold_q == HOLD_W'(MAX_HOLD));
  assign timeout     = timeout_q;
`else
  // MAX_HOLD has no effect in this build.
  logic [HOLD_W-1:0] w_unused_max_hold;
  assign w_unused_max_hold = HOLD_W'(MAX_HOLD);
  assign w_hold_done       = 1'b0;
  assign timeout           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    turn_d  = turn_q;
`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (w_valid) begin
          state_d = GRANT;
          gnt_d   = w_win;
          last_d  = w_win_idx;
`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        // Release and timeout may coincide; TURN is entered once either way.
        if (!w_req_own || w_hold_done) begin
          state_d = TURN;
          gnt_d   = '0;
          turn_d  = TURN_W'(1);
`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
          timeout_d = w_hold_done;
          hold_d    = '0;
`endif
        end else begin
`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      TURN: begin
        // The edge that ends the park is the edge that reaches IDLE, so the
        // IDLE arbitration is taken on it directly. This keeps the park gap
        // at exactly TURN_CYC cycles; req is only looked at on this edge.
        if (turn_q == TURN_W'(TURN_CYC)) begin
          if (w_valid) begin
            state_d = GRANT;
            gnt_d   = w_win;
            last_d  = w_win_idx;
`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
            hold_d  = HOLD_W'(1);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      oen_q   <= '1;
      // Rotation starts after the top index so req[0] wins first.
      last_q  <= OWN_W'(NREQ - 1);
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oen_q   <= ~gnt_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
    end
  end

`ifdef TBUF_BUS_ARBITER_TIMEOUT_EN
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt  = gnt_q;
  assign oen  = oen_q;
  assign busy = |gnt_q;

endmodule : tbuf_bus_arbiter
`default_nettype wire
